// File: rtl/rat_intr_ctrl.sv
// Interrupt source controller for the RAT CU _INT_ input: edge-detected pending, mask, fixed priority, EOI handshake.
// Optional source-ID read port enabled by defining INTC_ID_READ_EN.
module rat_intr_ctrl #(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] MASK_PORT = 8'hF0,
    parameter logic [7:0] CLR_PORT  = 8'hF1,
    parameter logic [7:0] ID_PORT   = 8'hF2
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ,
    input  logic             INT_ACK,
    input  logic             IO_STRB,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    output logic             INT,
    output logic [N_SRC-1:0] PENDING,
    output logic [2:0]       CUR_ID,
    output logic [7:0]       IN_DATA
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [2:0] f_lowest(input logic [N_SRC-1:0] v);
        f_lowest = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (v[i]) f_lowest = 3'(i);
    endfunction

    state_t           r_state;
    logic             r_int;
    logic [N_SRC-1:0] r_prev_irq;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic [2:0]       r_cur_id;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_elig;
    logic [N_SRC-1:0] w_clr;
    logic [2:0]       w_win;
    logic             w_any;
    logic             w_take;
    logic             w_mask_wr;
    logic             w_eoi;

    assign w_rise    = IRQ & ~r_prev_irq;
    assign w_elig    = r_pending & r_mask;
    assign w_any     = |w_elig;
    assign w_win     = f_lowest(w_elig);
    assign w_take    = (r_state == REQ) && INT_ACK && w_any;
    assign w_clr     = w_take ? (N_SRC'(1) << w_win) : '0;
    assign w_mask_wr = IO_STRB && (PORT_ID == MASK_PORT);
    assign w_eoi     = IO_STRB && (PORT_ID == CLR_PORT);

    // A rise in the same cycle as the acknowledge clear keeps the bit set.
    always_ff @(posedge clk) begin
        r_prev_irq <= IRQ;
        if (RESET) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_cur_id  <= 3'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_mask_wr) r_mask <= OUT_PORT[N_SRC-1:0];
            if (w_take)    r_cur_id <= w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= IDLE;
            r_int   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_state <= REQ;
                    r_int   <= 1'b1;
                end
                REQ: if (INT_ACK) begin
                    r_state <= SVC;
                    r_int   <= 1'b0;
                end else if (!w_any) begin
                    r_state <= IDLE;
                    r_int   <= 1'b0;
                end
                SVC: if (w_eoi) begin
                    r_state <= IDLE;
                    r_int   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_int   <= 1'b0;
                end
            endcase
        end
    end

    assign INT     = r_int;
    assign PENDING = r_pending;
    assign CUR_ID  = r_cur_id;

`ifdef INTC_ID_READ_EN
    assign IN_DATA = (PORT_ID == ID_PORT) ? {4'b0, |r_pending, r_cur_id} : 8'h00;
    logic w_unused;
    assign w_unused = &{1'b0, OUT_PORT};
`else
    assign IN_DATA = 8'h00;
    logic w_unused;
    assign w_unused = &{1'b0, OUT_PORT, ID_PORT};
`endif

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: directed scenarios followed by random traffic against a rule-level reference model.
module tb_rat_intr_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq;
    logic         ack;
    logic         strb;
    logic [7:0]   pid;
    logic [7:0]   dat;
    logic         int_o;
    logic [N-1:0] pend_o;
    logic [2:0]   cur_o;
    logic [7:0]   in_o;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: phase 0 = waiting, 1 = requesting, 2 = being serviced.
    bit [N-1:0] m_prev, m_pend, m_mask;
    int         m_phase;
    int         m_cur;

    rat_intr_ctrl dut (
        .clk(clk), .RESET(rst), .IRQ(irq), .INT_ACK(ack), .IO_STRB(strb),
        .PORT_ID(pid), .OUT_PORT(dat), .INT(int_o), .PENDING(pend_o),
        .CUR_ID(cur_o), .IN_DATA(in_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_in_data();
`ifdef INTC_ID_READ_EN
        if (pid == 8'hF2) return {4'b0, (m_pend != 0), 3'(m_cur)};
`endif
        return 8'h00;
    endfunction

    // Apply the behavioural rules to the inputs present at this clock edge.
    task automatic model_edge();
        bit [N-1:0] rise;
        int win;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_cur = 0; m_phase = 0; m_prev = irq;
            return;
        end
        rise = irq & ~m_prev;
        win = -1;
        for (int i = 0; i < N; i++)
            if (win < 0 && m_pend[i] && m_mask[i]) win = i;
        if (m_phase == 0) begin
            if (win >= 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (ack) begin
                m_phase = 2;
                if (win >= 0) begin
                    m_cur = win;
                    m_pend[win] = 1'b0;
                end
            end else if (win < 0) m_phase = 0;
        end else if (strb && pid == 8'hF1) m_phase = 0;
        m_pend = m_pend | rise;
        if (strb && pid == 8'hF0) m_mask = dat[N-1:0];
        m_prev = irq;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_int"},  32'(int_o),  32'(m_phase == 1));
        chk({tag, "_pend"}, 32'(pend_o), 32'(m_pend));
        chk({tag, "_cur"},  32'(cur_o),  32'(m_cur));
        chk({tag, "_in"},   32'(in_o),   32'(exp_in_data()));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] d, input string tag);
        strb = 1'b1; pid = port; dat = d;
        tick(tag);
        strb = 1'b0; pid = 8'h00; dat = 8'h00;
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick(tag);
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] ports [4];
        ports[0] = 8'hF0; ports[1] = 8'hF1; ports[2] = 8'hF2; ports[3] = 8'h00;
        m_prev = '0; m_pend = '0; m_mask = '0; m_phase = 0; m_cur = 0;
        rst = 1'b1; irq = 4'b0010; ack = 1'b0; strb = 1'b0; pid = 8'h00; dat = 8'h00;

        // 1: line high through reset is not an edge
        tick("t1_rst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick("t1_hold");
        chk("t1_pend_const", 32'(pend_o), 32'h0);
        chk("t1_int_const",  32'(int_o),  32'h0);

        // 2: single source through request/ack
        irq = 4'b0000;
        io_write(8'hF0, 8'h0F, "t2_mask");
        irq = 4'b0100;
        tick("t2_rise");
        chk("t2_pend_k", 32'(pend_o), 32'h4);
        chk("t2_int_k",  32'(int_o),  32'h0);
        tick("t2_req");
        chk("t2_int_k1", 32'(int_o), 32'h1);
        do_ack("t2_ack");
        chk("t2_cur_const", 32'(cur_o), 32'h2);
        chk("t2_pend_clr",  32'(pend_o), 32'h0);
        irq = 4'b0000;
        io_write(8'hF1, 8'h55, "t2_eoi");

        // 3: simultaneous requests, priority and EOI rearm
        irq = 4'b1010;
        tick("t3_rise");
        tick("t3_req");
        do_ack("t3_ack1");
        chk("t3_cur1",  32'(cur_o),  32'h1);
        chk("t3_pend1", 32'(pend_o), 32'h8);
        io_write(8'hF1, 8'h00, "t3_eoi");
        tick("t3_rearm");
        chk("t3_int_again", 32'(int_o), 32'h1);
        do_ack("t3_ack2");
        chk("t3_cur2", 32'(cur_o), 32'h3);
        io_write(8'hF1, 8'h00, "t3_eoi2");

        // 4: masking out the only eligible source withdraws the request
        irq = 4'b0000;
        tick("t4_low");
        irq = 4'b0001;
        tick("t4_rise");
        tick("t4_req");
        io_write(8'hF0, 8'h00, "t4_mask0");
        tick("t4_drop");
        chk("t4_int_drop", 32'(int_o),  32'h0);
        chk("t4_pend_kept", 32'(pend_o), 32'h1);
        io_write(8'hF0, 8'h01, "t4_mask1");
        tick("t4_rereq");
        chk("t4_int_back", 32'(int_o), 32'h1);

        // 5: rise coincident with acknowledge clear, then reset during service
        irq = 4'b0000;
        tick("t5_low");
        irq = 4'b0001;
        do_ack("t5_ack");
        chk("t5_pend_kept", 32'(pend_o), 32'h1);
        rst = 1'b1;
        tick("t5_rst");
        rst = 1'b0;
        chk("t5_int_rst",  32'(int_o),  32'h0);
        chk("t5_pend_rst", 32'(pend_o), 32'h0);
        irq = 4'b0000;
        tick("t5_low2");
        irq = 4'b0001;
        tick("t5_rise2");
        tick("t5_masked");
        chk("t5_mask_rst", 32'(int_o), 32'h0);

        // 6: ID read while servicing source 2 with source 3 pending
        irq = 4'b0000;
        io_write(8'hF0, 8'h0E, "t6_mask");
        irq = 4'b0100;
        tick("t6_rise");
        tick("t6_req");
        do_ack("t6_ack");
        irq = 4'b1100;
        tick("t6_rise3");
        pid = 8'hF2;
        #1 compare("t6_rd");
`ifdef INTC_ID_READ_EN
        chk("t6_id_const", 32'(in_o), 32'h0A);
`endif
        pid = 8'h00;
        #1 compare("t6_rd0");
        chk("t6_zero_const", 32'(in_o), 32'h0);
        rst = 1'b1;
        tick("t6_rst");
        rst = 1'b0;

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) irq[b] = ~irq[b];
            ack  = ($urandom_range(3) == 0);
            strb = ($urandom_range(4) == 0);
            pid  = ports[$urandom_range(3)];
            dat  = 8'($urandom);
            rst  = ($urandom_range(199) == 0);
            #1 chk("rnd_in_comb", 32'(in_o), 32'(exp_in_data()));
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
